spi_rom_cfg_ctrl: RTL

Sequencer that walks the `spi_config_rom` block memory (AD9517 register table, 24-bit words) and hands each word, in address order, to the SPI master as one write transaction. It sits between the ROM and the SPI master. A single `start` pulse after power-up or reset programs the whole clock chip. It reports `busy`, `done` and a timeout `error` to the board-level control logic.

---
 rtl/spi_cfg_pkg.sv | 23 ++
 rtl/spi_rom_cfg_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared types and defaults for the SPI configuration-ROM sequencer.
package spi_cfg_pkg;

  localparam int unsigned CFG_ADDR_W    = 7;
  localparam int unsigned CFG_DATA_W    = 24;
  localparam int unsigned CFG_NUM_WORDS = 64;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    ISSUE,
    WAIT_DONE,
    GAP,
    FINISH
  } cfg_state_t;

  // Width of a counter that must be able to hold the value TIMEOUT.
  function automatic int unsigned to_cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/spi_rom_cfg_ctrl.sv
// Walks the configuration ROM in address order and issues each word as one
// SPI write, reporting busy/done/timeout to the board controller.
module spi_rom_cfg_ctrl
  import spi_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W     = CFG_ADDR_W,
  parameter int unsigned DATA_W     = CFG_DATA_W,
  parameter int unsigned NUM_WORDS  = CFG_NUM_WORDS,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              rom_ena,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              spi_cmd_valid,
  output logic [DATA_W-1:0] spi_cmd_data,
  input  logic              spi_cmd_ready,
  input  logic              spi_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned TO_W     = to_cnt_width(TIMEOUT);
  localparam int unsigned LAT_W    = 2;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(NUM_WORDS);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(ROM_LAT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(GAP_LAST);

  // Reject parameter sets the sequencer cannot honour.
  if (NUM_WORDS < 1 || NUM_WORDS > (2 ** ADDR_W)) begin : g_bad_num_words
    $error("NUM_WORDS must be within 1..2**ADDR_W");
  end
  if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_rom_lat
    $error("ROM_LAT must be within 1..3");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  cfg_state_t         state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               rom_ena_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               valid_d;
  logic [DATA_W-1:0]  data_d;
  logic               busy_d;
  logic               done_d;
  logic               error_d;

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    gap_d   = gap_q;
    to_d    = to_q;
    addr_d  = rom_addr;
    cnt_d   = word_cnt;
    valid_d = spi_cmd_valid;
    data_d  = spi_cmd_data;
    busy_d  = busy;
    done_d  = done;
    error_d = error;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        state_d = WAIT_ROM;
        lat_d   = '0;
      end
      WAIT_ROM: begin
        if (lat_q == LAT_LAST) begin
          data_d  = rom_data;
          valid_d = 1'b1;
          state_d = ISSUE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ISSUE: begin
        if (spi_cmd_ready) begin
          valid_d = 1'b0;
          to_d    = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A completion on the timeout edge still counts as success.
        if (spi_done) begin
          if (word_cnt != MAX_CNT) begin
            cnt_d = word_cnt + 1'b1;
          end
          if (rom_addr == LAST_ADDR) begin
            state_d = FINISH;
          end else begin
            addr_d  = rom_addr + 1'b1;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? FETCH : GAP;
          end
        end else if (to_q == TO_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_END) begin
          state_d = FETCH;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The ROM is enabled for exactly the one cycle spent in FETCH.
    rom_ena_d = (state_d == FETCH);
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      lat_q         <= '0;
      gap_q         <= '0;
      to_q          <= '0;
      rom_ena       <= 1'b0;
      rom_addr      <= '0;
      word_cnt      <= '0;
      spi_cmd_valid <= 1'b0;
      spi_cmd_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_q         <= lat_d;
      gap_q         <= gap_d;
      to_q          <= to_d;
      rom_ena       <= rom_ena_d;
      rom_addr      <= addr_d;
      word_cnt      <= cnt_d;
      spi_cmd_valid <= valid_d;
      spi_cmd_data  <= data_d;
      busy          <= busy_d;
      done          <= done_d;
      error         <= error_d;
    end
  end

endmodule
